// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Hazard, forwarding and memory-hold controller for a classic 5-stage
// (IF/ID/EX/MEM/WB) in-order pipeline.
//
// The controller keeps a 3-entry scoreboard (EX, MEM, WB) of the instructions
// that sit in ID/EX, EX/MEM and MEM/WB. The ID instruction is compared
// against it to decide stalls and operand forwarding.
//
// Build option:
//   PIPELINE_CTRL_FWD_EN  defined   -> forwarding; stall only on load-use.
//                         undefined -> no forwarding (selects tied to 0);
//                                      stall while any used source register
//                                      matches the EX, MEM or WB entry.
//
// Parameters:
//   REG_WIDTH    register address width
//   CNT_WIDTH    width of the saturating stall-cycle counter
//   MEM_TIMEOUT  consecutive busy cycles before o_Timeout is raised
//
// Ports:
//   i_Clock          clock, rising edge
//   i_Reset          synchronous, active-low reset
//   i_IDValid        ID holds a valid instruction
//   i_IDRs1Addr/Used, i_IDRs2Addr/Used  ID source registers and read flags
//   i_IDRdAddr, i_IDRdWrEnable          ID destination register / write flag
//   i_IDIsLoad       ID instruction is a load
//   i_IDBranchTaken  ID resolved a taken branch/jump
//   i_MemBusy        data memory not ready; MEM must hold
//   o_IFStall        hold PC and IF/ID
//   o_IDEXBubble     load NOP into ID/EX
//   o_IFIDFlush      load NOP into IF/ID
//   o_PipeHold       freeze PC, IF/ID, ID/EX, EX/MEM
//   o_MEMWBBubble    load NOP into MEM/WB
//   o_FwdASel/BSel   EX operand source: 0 ID/EX, 1 EX/MEM, 2 MEM/WB
//   o_StallCount     saturating count of stall/hold cycles
//   o_Timeout        memory busy for MEM_TIMEOUT consecutive cycles
// ---------------------------------------------------------------------------

module pipeline_ctrl #(
  parameter int REG_WIDTH   = 5,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_IDValid,
  input  logic [REG_WIDTH-1:0] i_IDRs1Addr,
  input  logic [REG_WIDTH-1:0] i_IDRs2Addr,
  input  logic                 i_IDRs1Used,
  input  logic                 i_IDRs2Used,
  input  logic [REG_WIDTH-1:0] i_IDRdAddr,
  input  logic                 i_IDRdWrEnable,
  input  logic                 i_IDIsLoad,
  input  logic                 i_IDBranchTaken,
  input  logic                 i_MemBusy,
  output logic                 o_IFStall,
  output logic                 o_IDEXBubble,
  output logic                 o_IFIDFlush,
  output logic                 o_PipeHold,
  output logic                 o_MEMWBBubble,
  output logic [1:0]           o_FwdASel,
  output logic [1:0]           o_FwdBSel,
  output logic [CNT_WIDTH-1:0] o_StallCount,
  output logic                 o_Timeout
);

  localparam int TO_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [REG_WIDTH-1:0] REG_ZERO = {REG_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [TO_W-1:0]      TO_MAX   = TO_W'(MEM_TIMEOUT);

  // An entry's valid bit already folds in the write enable, so a hit needs
  // only valid, a non-zero rd and an address match on a source that is read.
  function automatic logic reg_hit(input logic                 ent_valid,
                                   input logic [REG_WIDTH-1:0] ent_rd,
                                   input logic [REG_WIDTH-1:0] rs,
                                   input logic                 rs_used);
    return ent_valid & rs_used & (ent_rd != REG_ZERO) & (ent_rd == rs);
  endfunction

  // Scoreboard: index by stage name
  logic                 ex_valid_q,  ex_valid_d;
  logic [REG_WIDTH-1:0] ex_rd_q,     ex_rd_d;
  logic                 ex_load_q,   ex_load_d;
  logic                 mem_valid_q, mem_valid_d;
  logic [REG_WIDTH-1:0] mem_rd_q,    mem_rd_d;
  logic                 mem_load_q,  mem_load_d;
  logic                 wb_valid_q,  wb_valid_d;
  logic [REG_WIDTH-1:0] wb_rd_q,     wb_rd_d;
  logic                 wb_load_q,   wb_load_d;

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [TO_W-1:0]      to_cnt_q,    to_cnt_d;
  logic                 timeout_q,   timeout_d;

  logic ex_hit1_s, ex_hit2_s, mem_hit1_s, mem_hit2_s;
  logic stall_s;
  logic flush_s;
  logic id_enter_s;
  logic unused_s;

  assign ex_hit1_s  = reg_hit(ex_valid_q,  ex_rd_q,  i_IDRs1Addr, i_IDRs1Used);
  assign ex_hit2_s  = reg_hit(ex_valid_q,  ex_rd_q,  i_IDRs2Addr, i_IDRs2Used);
  assign mem_hit1_s = reg_hit(mem_valid_q, mem_rd_q, i_IDRs1Addr, i_IDRs1Used);
  assign mem_hit2_s = reg_hit(mem_valid_q, mem_rd_q, i_IDRs2Addr, i_IDRs2Used);

`ifdef PIPELINE_CTRL_FWD_EN
  // With forwarding only a load result still in EX cannot reach the consumer.
  assign stall_s  = i_IDValid & ex_load_q & (ex_hit1_s | ex_hit2_s);
  // The WB entry and older load flags only mirror the pipe in this build.
  assign unused_s = ^{mem_load_q, wb_valid_q, wb_rd_q, wb_load_q};
`else
  logic wb_hit1_s, wb_hit2_s;
  assign wb_hit1_s = reg_hit(wb_valid_q, wb_rd_q, i_IDRs1Addr, i_IDRs1Used);
  assign wb_hit2_s = reg_hit(wb_valid_q, wb_rd_q, i_IDRs2Addr, i_IDRs2Used);
  // Without forwarding the consumer waits until the producer has left WB.
  assign stall_s   = i_IDValid & (ex_hit1_s | ex_hit2_s | mem_hit1_s |
                                  mem_hit2_s | wb_hit1_s | wb_hit2_s);
  assign unused_s  = ^{ex_load_q, mem_load_q, wb_load_q};
`endif

  // A branch is acted on only once the instruction may really leave ID.
  assign flush_s    = i_IDValid & i_IDBranchTaken & ~stall_s & ~i_MemBusy;
  // Only writers are tracked; bubbled and flushed slots enter EX empty.
  assign id_enter_s = i_IDValid & i_IDRdWrEnable & ~stall_s & ~flush_s;

  assign o_PipeHold    = i_MemBusy;
  assign o_MEMWBBubble = i_MemBusy;

  // Pipeline steering: hold outranks stall, stall outranks flush; quiet in reset
  always_comb begin
    o_IFStall    = 1'b0;
    o_IDEXBubble = 1'b0;
    o_IFIDFlush  = 1'b0;
    if (!i_Reset) begin
      o_IFStall    = 1'b0;
      o_IDEXBubble = 1'b0;
      o_IFIDFlush  = 1'b0;
    end else if (i_MemBusy) begin
      o_IFStall    = 1'b0;
      o_IDEXBubble = 1'b0;
      o_IFIDFlush  = 1'b0;
    end else if (stall_s) begin
      o_IFStall    = 1'b1;
      o_IDEXBubble = 1'b1;
      o_IFIDFlush  = 1'b0;
    end else begin
      o_IFStall    = 1'b0;
      o_IDEXBubble = 1'b0;
      o_IFIDFlush  = flush_s;
    end
  end

  // Next state of the scoreboard, stall counter and busy timeout
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rd_d     = ex_rd_q;
    ex_load_d   = ex_load_q;
    mem_valid_d = mem_valid_q;
    mem_rd_d    = mem_rd_q;
    mem_load_d  = mem_load_q;
    wb_valid_d  = wb_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_load_d   = wb_load_q;
    stall_cnt_d = stall_cnt_q;
    to_cnt_d    = to_cnt_q;
    timeout_d   = timeout_q;

    if (i_MemBusy) begin
      // EX and MEM freeze; the stalled MEM stage emits a NOP into WB.
      wb_valid_d = 1'b0;
      wb_rd_d    = REG_ZERO;
      wb_load_d  = 1'b0;
    end else begin
      ex_valid_d  = id_enter_s;
      ex_rd_d     = i_IDRdAddr;
      ex_load_d   = i_IDIsLoad;
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;
      mem_load_d  = ex_load_q;
      wb_valid_d  = mem_valid_q;
      wb_rd_d     = mem_rd_q;
      wb_load_d   = mem_load_q;
    end

    if ((stall_s | i_MemBusy) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1'b1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    if (i_MemBusy) begin
      if (to_cnt_q != TO_MAX) begin
        to_cnt_d = to_cnt_q + TO_W'(1'b1);
      end else begin
        to_cnt_d = to_cnt_q;
      end
      timeout_d = (to_cnt_d == TO_MAX);
    end else begin
      to_cnt_d  = {TO_W{1'b0}};
      timeout_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= REG_ZERO;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= REG_ZERO;
      mem_load_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= REG_ZERO;
      wb_load_q   <= 1'b0;
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
      to_cnt_q    <= {TO_W{1'b0}};
      timeout_q   <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_load_q  <= mem_load_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_load_q   <= wb_load_d;
      stall_cnt_q <= stall_cnt_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_StallCount = stall_cnt_q;
  assign o_Timeout    = timeout_q;

`ifdef PIPELINE_CTRL_FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  // Youngest producer wins: EX/MEM result before MEM/WB data.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit) begin
      return 2'd1;
    end else if (mem_hit) begin
      return 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

  // Forward selects travel with the instruction into ID/EX
  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (i_MemBusy) begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
    end else if (stall_s || !i_IDValid) begin
      fwd_a_d = 2'd0;
      fwd_b_d = 2'd0;
    end else begin
      fwd_a_d = fwd_sel(ex_hit1_s, mem_hit1_s);
      fwd_b_d = fwd_sel(ex_hit2_s, mem_hit2_s);
    end
  end

  // Forward-select registers with synchronous active-low reset
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      fwd_a_q <= 2'd0;
      fwd_b_q <= 2'd0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign o_FwdASel = fwd_a_q;
  assign o_FwdBSel = fwd_b_q;
`else
  assign o_FwdASel = 2'd0;
  assign o_FwdBSel = 2'd0;
`endif

endmodule
